ram_1p_initiator: RTL and testbench

RAM_1P_INITIATOR -- requirements
Module: ram_1p_initiator

---
 rtl/ram_1p_initiator_pkg.sv | 18 +
 rtl/ram_1p_init_resp_fifo.sv | 57 +++++
 rtl/ram_1p_initiator.sv | 153 +++++++++++++++
 tb/tb_ram_1p_initiator.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_1p_initiator_pkg.sv
// rtl/ram_1p_initiator_pkg.sv - shared types and constants for the RAM initiator
package ram_1p_initiator_pkg;

    localparam int ErrCntWidth = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INIT_PEND = 2'd1,
        INIT      = 2'd2,
        READY     = 2'd3
    } init_state_e;

    // Address width that stays at least one bit for a single-word RAM.
    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/ram_1p_init_resp_fifo.sv
// rtl/ram_1p_init_resp_fifo.sv - registered read-response FIFO, no overflow guard (caller credits it)
module ram_1p_init_resp_fifo #(
    parameter int Depth = 3,
    parameter int Width = 34
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_tvalid_i,
    input  logic [Width-1:0] s_tdata_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic [Width-1:0] m_tdata_o
);

    localparam int PtrW = (Depth <= 2) ? 1 : $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  count_q;
    logic             push;
    logic             pop;

    assign push       = s_tvalid_i;
    assign m_tvalid_o = (count_q != '0);
    assign pop        = m_tvalid_o & m_tready_i;
    // An empty FIFO presents zeros rather than stale data.
    assign m_tdata_o  = m_tvalid_o ? mem_q[rptr_q] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= s_tdata_i;
        end
    end

endmodule

// File: rtl/ram_1p_initiator.sv
// rtl/ram_1p_initiator.sv - single-port RAM initiator with zero-fill sweep and credited reads
module ram_1p_initiator
    import ram_1p_initiator_pkg::*;
#(
    parameter int Depth       = 512,
    parameter int Width       = 32,
    parameter int ReadLatency = 1,
    localparam int Aw         = vbits(Depth),
    localparam int RespDepth  = ReadLatency + 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   init_req_i,
    output logic                   init_done_o,
    input  logic                   host_req_i,
    input  logic                   host_write_i,
    input  logic [Aw-1:0]          host_addr_i,
    input  logic [Width-1:0]       host_wdata_i,
    input  logic [Width-1:0]       host_wmask_i,
    output logic                   host_gnt_o,
    output logic                   host_rvalid_o,
    input  logic                   host_rready_i,
    output logic [Width-1:0]       host_rdata_o,
    output logic [1:0]             host_rerror_o,
    output logic                   ram_req_o,
    output logic                   ram_write_o,
    output logic [Aw-1:0]          ram_addr_o,
    output logic [Width-1:0]       ram_wdata_o,
    output logic [Width-1:0]       ram_wmask_o,
    input  logic                   ram_rvalid_i,
    input  logic [Width-1:0]       ram_rdata_i,
    input  logic [1:0]             ram_rerror_i,
    input  logic                   err_clr_i,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam int CrW = $clog2(RespDepth + 1);

    init_state_e      state_q;
    logic [Aw-1:0]    init_addr_q;
    logic [CrW-1:0]   credits_q;
    logic [CrW-1:0]   inflight_q;
    logic             fwd;
    logic             rd_gnt;
    logic             rsp_pop;
    logic             err_inc;
    logic [Width+1:0] rsp_tdata;

    assign fwd        = (state_q == IDLE) || (state_q == READY);
    assign host_gnt_o = host_req_i & fwd & (host_write_i | (credits_q != '0));
    assign rd_gnt     = host_gnt_o & ~host_write_i;
    assign rsp_pop    = host_rvalid_o & host_rready_i;
    assign err_inc    = ram_rvalid_i & ram_rerror_i[1];

    // The RAM bus idles at zero whenever nothing is being issued.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (state_q == INIT) begin
            ram_req_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_addr_o  = init_addr_q;
            ram_wmask_o = '1;
        end else if (host_gnt_o) begin
            ram_req_o   = 1'b1;
            ram_write_o = host_write_i;
            ram_addr_o  = host_addr_i;
            ram_wdata_o = host_wdata_i;
            ram_wmask_o = host_wmask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            init_addr_q <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE, READY: begin
                    if (init_req_i) begin
                        state_q     <= INIT_PEND;
                        init_done_o <= 1'b0;
                    end
                end
                // Wait for outstanding reads so the sweep cannot overtake them.
                INIT_PEND: begin
                    if (inflight_q == '0) begin
                        state_q     <= INIT;
                        init_addr_q <= '0;
                    end
                end
                INIT: begin
                    if (init_addr_q == Aw'(Depth - 1)) begin
                        state_q     <= READY;
                        init_done_o <= 1'b1;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q  <= CrW'(RespDepth);
            inflight_q <= '0;
        end else begin
            if (rd_gnt && !rsp_pop) begin
                credits_q <= credits_q - 1'b1;
            end else if (rsp_pop && !rd_gnt) begin
                credits_q <= credits_q + 1'b1;
            end
            if (rd_gnt && !ram_rvalid_i) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (ram_rvalid_i && !rd_gnt) begin
                inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= err_inc ? ErrCntWidth'(1) : '0;
        end else if (err_inc && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    ram_1p_init_resp_fifo #(
        .Depth (RespDepth),
        .Width (Width + 2)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s_tvalid_i (ram_rvalid_i),
        .s_tdata_i  ({ram_rdata_i, ram_rerror_i}),
        .m_tvalid_o (host_rvalid_o),
        .m_tready_i (host_rready_i),
        .m_tdata_o  (rsp_tdata)
    );

    assign host_rdata_o  = rsp_tdata[Width+1:2];
    assign host_rerror_o = rsp_tdata[1:0];

endmodule

// File: tb/tb_ram_1p_initiator.sv
// tb/tb_ram_1p_initiator.sv - directed bench for ram_1p_initiator with a 2-cycle RAM model
module tb_ram_1p_initiator;
    import ram_1p_initiator_pkg::*;

    localparam int Depth = 16;
    localparam int Width = 32;
    localparam int ReadLatency = 2;
    localparam int Aw = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             init_req_i = 1'b0;
    logic             init_done_o;
    logic             host_req_i = 1'b0;
    logic             host_write_i = 1'b0;
    logic [Aw-1:0]    host_addr_i = '0;
    logic [Width-1:0] host_wdata_i = '0;
    logic [Width-1:0] host_wmask_i = '0;
    logic             host_gnt_o;
    logic             host_rvalid_o;
    logic             host_rready_i = 1'b1;
    logic [Width-1:0] host_rdata_o;
    logic [1:0]       host_rerror_o;
    logic             ram_req_o;
    logic             ram_write_o;
    logic [Aw-1:0]    ram_addr_o;
    logic [Width-1:0] ram_wdata_o;
    logic [Width-1:0] ram_wmask_o;
    logic             ram_rvalid_i;
    logic [Width-1:0] ram_rdata_i;
    logic [1:0]       ram_rerror_i;
    logic             err_clr_i = 1'b0;
    logic [15:0]      err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    ram_1p_initiator #(
        .Depth       (Depth),
        .Width       (Width),
        .ReadLatency (ReadLatency)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .init_req_i    (init_req_i),
        .init_done_o   (init_done_o),
        .host_req_i    (host_req_i),
        .host_write_i  (host_write_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_wmask_i  (host_wmask_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rready_i (host_rready_i),
        .host_rdata_o  (host_rdata_o),
        .host_rerror_o (host_rerror_o),
        .ram_req_o     (ram_req_o),
        .ram_write_o   (ram_write_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_wmask_o   (ram_wmask_o),
        .ram_rvalid_i  (ram_rvalid_i),
        .ram_rdata_i   (ram_rdata_i),
        .ram_rerror_i  (ram_rerror_i),
        .err_clr_i     (err_clr_i),
        .err_cnt_o     (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: masked writes, reads return two cycles after the request.
    logic [Width-1:0] mem [Depth];
    logic             v1 = 1'b0, v2 = 1'b0;
    logic [Aw-1:0]    a1 = '0, a2 = '0;
    logic [1:0]       e1 = '0, e2 = '0;
    logic [1:0]       err_next = '0;
    logic [1:0]       junk_err = '0;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            for (int i = 0; i < Depth; i++) mem[i] <= '1;
        end else begin
            v1 <= ram_req_o & ~ram_write_o;
            a1 <= ram_addr_o;
            e1 <= err_next;
            v2 <= v1;
            a2 <= a1;
            e2 <= e1;
            if (ram_req_o && ram_write_o)
                mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
        end
    end

    assign ram_rvalid_i = v2;
    assign ram_rdata_i  = v2 ? mem[a2] : '0;
    assign ram_rerror_i = v2 ? e2 : junk_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [Width+1:0] exp_q [$];

    always @(negedge clk_i) begin
        if (rst_ni && host_rvalid_o && host_rready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_extra: got %0h want no response", {host_rdata_o, host_rerror_o});
            end else begin
                check("rsp_data", {host_rdata_o, host_rerror_o}, exp_q.pop_front());
            end
        end
    end

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [Aw-1:0] addr,
                         input logic [Width-1:0] wd, input logic [Width-1:0] wm);
        host_req_i   = req;
        host_write_i = wr;
        host_addr_i  = addr;
        host_wdata_i = wd;
        host_wmask_i = wm;
    endtask

    task automatic drain(input string name);
        int k = 0;
        next();
        host_req_i    = 1'b0;
        host_rready_i = 1'b1;
        err_clr_i     = 1'b0;
        while (exp_q.size() != 0 && k < 20) begin
            next();
            k++;
        end
        check(name, 64'(exp_q.size()), 0);
    endtask

    // Expects the current cycle to be at or before the first sweep write.
    task automatic sweep(input string name);
        int k = 0;
        #1;
        while (!(ram_req_o && !host_gnt_o) && k < 8) begin
            check({name, "_pend_gnt"}, host_gnt_o, 0);
            next();
            #1;
            k++;
        end
        check({name, "_start"}, ram_req_o && !host_gnt_o, 1);
        for (int i = 0; i < Depth; i++) begin
            if (i > 0) begin
                next();
                init_req_i = (i == 8);
                #1;
            end
            check({name, "_ctl"}, {ram_req_o, ram_write_o, host_gnt_o, init_done_o}, 4'b1100);
            check({name, "_addr"}, ram_addr_o, i);
            check({name, "_wdata"}, ram_wdata_o, 0);
            check({name, "_wmask"}, ram_wmask_o, 32'hFFFF_FFFF);
        end
        next();
        init_req_i = 1'b0;
        host_req_i = 1'b0;
        #1;
        check({name, "_done"}, init_done_o, 1);
        check({name, "_end_req"}, ram_req_o, 0);
    endtask

    typedef struct {
        logic             req;
        logic             wr;
        logic [Aw-1:0]    addr;
        logic [Width-1:0] wdata;
        logic [Width-1:0] wmask;
        logic [1:0]       err;
        logic [Width-1:0] rdata;
    } vec_t;

    vec_t             vecs [10];
    logic [Aw-1:0]    rd_addr [8];
    logic [Width-1:0] rd_data [8];
    logic [15:0]      err_exp [9];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'd3,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'b00, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 4'd7,  32'h1234_5678, 32'h0000_FFFF, 2'b00, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 4'd5,  32'h0,         32'h0,         2'b00, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 4'd3,  32'h0,         32'hFF00_0000, 2'b00, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 4'd15, 32'hA5A5_A5A5, 32'hF0F0_F0F0, 2'b00, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 4'd3,  32'h0, 32'h0, 2'b00, 32'h00AD_BEEF};
        vecs[6] = '{1'b1, 1'b0, 4'd7,  32'h0, 32'h0, 2'b00, 32'h0000_5678};
        vecs[7] = '{1'b1, 1'b0, 4'd15, 32'h0, 32'h0, 2'b01, 32'hA0A0_A0A0};
        vecs[8] = '{1'b1, 1'b0, 4'd0,  32'h0, 32'h0, 2'b01, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 4'd9,  32'h0, 32'h0, 2'b00, 32'h0};
        rd_addr = '{4'd3, 4'd7, 4'd15, 4'd0, 4'd7, 4'd3, 4'd15, 4'd1};
        rd_data = '{32'h00AD_BEEF, 32'h0000_5678, 32'hA0A0_A0A0, 32'h0,
                    32'h0000_5678, 32'h00AD_BEEF, 32'hA0A0_A0A0, 32'h0};
        err_exp = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd1, 16'd1, 16'd0};

        // Reset values
        next();
        next();
        check("rst_init_done", init_done_o, 0);
        check("rst_rvalid", host_rvalid_o, 0);
        check("rst_gnt", host_gnt_o, 0);
        check("rst_ram_req", ram_req_o, 0);
        check("rst_ram_addr", ram_addr_o, 0);
        check("rst_ram_wdata", ram_wdata_o, 0);
        check("rst_rdata", host_rdata_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        next();
        rst_ni = 1'b1;

        // Zero-fill sweep; a second init_req mid-sweep must be ignored
        next();
        init_req_i = 1'b1;
        next();
        init_req_i = 1'b0;
        drive(1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF, 32'h0);
        sweep("sweep1");

        // Vector table: forwarding of writes, idle, and reads with expected data
        for (int i = 0; i < 10; i++) begin
            next();
            drive(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            err_next = vecs[i].err;
            #1;
            check("vec_gnt", host_gnt_o, vecs[i].req);
            check("vec_ram_req", ram_req_o, vecs[i].req);
            if (vecs[i].req) begin
                check("vec_ram_write", ram_write_o, vecs[i].wr);
                check("vec_ram_addr", ram_addr_o, vecs[i].addr);
                if (vecs[i].wr) begin
                    check("vec_ram_wdata", ram_wdata_o, vecs[i].wdata);
                    check("vec_ram_wmask", ram_wmask_o, vecs[i].wmask);
                end else begin
                    exp_q.push_back({vecs[i].rdata, vecs[i].err});
                end
            end
        end
        drain("vec_drain");
        err_next = 2'b00;
        check("corr_err_not_counted", err_cnt_o, 0);

        // Back-to-back reads with host_rready high
        for (int k = 0; k < 8; k++) begin
            next();
            drive(1'b1, 1'b0, rd_addr[k], 32'h0, 32'h0);
            #1;
            check("b2b_gnt", host_gnt_o, 1);
            check("b2b_rvalid", host_rvalid_o, k >= 3);
            exp_q.push_back({rd_data[k], 2'b00});
        end
        drain("b2b_drain");

        // Credit exhaustion with host_rready low, then one pop frees one grant
        for (int k = 0; k < 8; k++) begin
            next();
            drive(1'b1, 1'b0, rd_addr[k % 4], 32'h0, 32'h0);
            host_rready_i = 1'b0;
            #1;
            check("cred_gnt", host_gnt_o, k < 4);
            if (k < 4) exp_q.push_back({rd_data[k % 4], 2'b00});
            if (k >= 4) begin
                check("hold_rvalid", host_rvalid_o, 1);
                check("hold_rdata", host_rdata_o, 32'h00AD_BEEF);
            end
        end
        next();
        host_rready_i = 1'b1;
        host_addr_i   = 4'd3;
        #1;
        check("cred_pop_gnt", host_gnt_o, 0);
        next();
        host_rready_i = 1'b0;
        #1;
        check("cred_one_more", host_gnt_o, 1);
        exp_q.push_back({32'h00AD_BEEF, 2'b00});
        for (int k = 0; k < 2; k++) begin
            next();
            #1;
            check("cred_blocked", host_gnt_o, 0);
        end
        drain("cred_drain");

        // Uncorrectable error counting and clear; stray rerror while rvalid low is noise
        junk_err = 2'b10;
        for (int k = 0; k < 9; k++) begin
            next();
            drive(k < 4, 1'b0, 4'd3, 32'h0, 32'h0);
            err_next  = 2'b10;
            err_clr_i = (k == 5) || (k == 7);
            #1;
            if (k < 4) begin
                check("err_gnt", host_gnt_o, 1);
                exp_q.push_back({32'h00AD_BEEF, 2'b10});
            end
            check("err_cnt", err_cnt_o, err_exp[k]);
        end
        drain("err_drain");
        err_next = 2'b00;

        // Init request with two reads outstanding
        next();
        drive(1'b1, 1'b0, 4'd7, 32'h0, 32'h0);
        #1;
        check("pend_rd0_gnt", host_gnt_o, 1);
        exp_q.push_back({32'h0000_5678, 2'b00});
        next();
        host_addr_i = 4'd15;
        init_req_i  = 1'b1;
        #1;
        check("pend_rd1_gnt", host_gnt_o, 1);
        exp_q.push_back({32'hA0A0_A0A0, 2'b00});
        next();
        init_req_i  = 1'b0;
        host_addr_i = 4'd3;
        #1;
        check("pend_state0", dut.state_q, INIT_PEND);
        check("pend_done_clr", init_done_o, 0);
        check("pend_gnt0", host_gnt_o, 0);
        next();
        #1;
        check("pend_state1", dut.state_q, INIT_PEND);
        check("pend_gnt1", host_gnt_o, 0);
        sweep("sweep2");
        drain("pend_drain");

        // Reset in the middle of a sweep
        next();
        init_req_i = 1'b1;
        next();
        init_req_i = 1'b0;
        begin
            int k = 0;
            #1;
            while (!ram_req_o && k < 8) begin
                next();
                #1;
                k++;
            end
        end
        check("abort_addr0", ram_addr_o, 0);
        for (int k = 0; k < 5; k++) next();
        #1;
        check("abort_addr5", ram_addr_o, 5);
        rst_ni = 1'b0;
        #1;
        check("abort_ram_req", ram_req_o, 0);
        check("abort_init_done", init_done_o, 0);
        check("abort_ram_addr", ram_addr_o, 0);
        next();
        next();
        rst_ni = 1'b1;
        #1;
        check("abort_state", dut.state_q, IDLE);
        for (int k = 0; k < 20; k++) next();
        check("abort_stays_idle", {ram_req_o, init_done_o}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
